// File: rtl/soc_bus_arbiter.sv
// rtl/soc_bus_arbiter.sv - two-master / one-slave request/data_valid bus arbiter
//
// Purpose: grants one transaction at a time to the cpu core (m0) or the UART
// programming loader (m1), forwards the owner's address/write fields to the
// slave, routes the completion back to the owner, and aborts a transaction the
// slave never completes so the bus cannot hang.
//
// Ports:
//   clk, reset                 rising-edge clock, asynchronous active-high reset
//   programming                1 = loader mode, m0 is never granted
//   m0_* / m1_*                req_valid, addr, we, wrt_data in; rd_data, data_valid out
//   s_req_valid/addr/we/wrt_data  request to the slave (valid while BUSY)
//   s_rd_data, s_data_valid    slave completion
//   grant                      one-hot owner {m1,m0}, 00 = idle
//   bus_err                    1-cycle pulse on timeout abort
module soc_bus_arbiter #(
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    TIMEOUT_CYCLES = 256,
    parameter logic [DATA_WIDTH-1:0] ERR_DATA       = 32'hDEADBEEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  programming,

    input  logic                  m0_req_valid,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic                  m0_we,
    input  logic [DATA_WIDTH-1:0] m0_wrt_data,
    output logic [DATA_WIDTH-1:0] m0_rd_data,
    output logic                  m0_data_valid,

    input  logic                  m1_req_valid,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic                  m1_we,
    input  logic [DATA_WIDTH-1:0] m1_wrt_data,
    output logic [DATA_WIDTH-1:0] m1_rd_data,
    output logic                  m1_data_valid,

    output logic                  s_req_valid,
    output logic [ADDR_WIDTH-1:0] s_addr,
    output logic                  s_we,
    output logic [DATA_WIDTH-1:0] s_wrt_data,
    input  logic [DATA_WIDTH-1:0] s_rd_data,
    input  logic                  s_data_valid,

    output logic [1:0]            grant,
    output logic                  bus_err
);

    localparam int TIMER_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           grant_q, grant_d;
    logic                 rr_last_q, rr_last_d;   // 0 = m0 served last, 1 = m1
    logic [TIMER_W-1:0]   timer_q, timer_d;

    logic                 m0_elig;
    logic                 m1_elig;
    logic                 win_m1;
    logic                 timeout;
    logic                 done;
    logic [DATA_WIDTH-1:0] rsp_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            grant_q   <= 2'b00;
            rr_last_q <= 1'b1;
            timer_q   <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_last_q <= rr_last_d;
            timer_q   <= timer_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        rr_last_d     = rr_last_q;
        timer_d       = timer_q;

        s_req_valid   = 1'b0;
        s_addr        = '0;
        s_we          = 1'b0;
        s_wrt_data    = '0;
        m0_data_valid = 1'b0;
        m0_rd_data    = '0;
        m1_data_valid = 1'b0;
        m1_rd_data    = '0;
        bus_err       = 1'b0;

        m0_elig  = m0_req_valid && !programming;
        m1_elig  = m1_req_valid;
        // m1 wins when it is the only candidate, or when both compete and
        // m0 was the last one served.
        win_m1   = m1_elig && (!m0_elig || !rr_last_q);
        timeout  = 1'b0;
        done     = 1'b0;
        rsp_data = '0;

        case (state_q)
            ST_IDLE: begin
                // s_data_valid is deliberately ignored here.
                if (m0_elig || m1_elig) begin
                    grant_d   = win_m1 ? 2'b10 : 2'b01;
                    rr_last_d = win_m1;
                    timer_d   = '0;
                    state_d   = ST_BUSY;
                end
            end

            ST_BUSY: begin
                s_req_valid = 1'b1;
                if (grant_q[1]) begin
                    s_addr     = m1_addr;
                    s_we       = m1_we;
                    s_wrt_data = m1_wrt_data;
                end else begin
                    s_addr     = m0_addr;
                    s_we       = m0_we;
                    s_wrt_data = m0_wrt_data;
                end

                // A real completion on the final cycle takes priority over the abort.
                timeout  = (timer_q == TIMER_LAST);
                done     = s_data_valid || timeout;
                rsp_data = s_data_valid ? s_rd_data : ERR_DATA;
                bus_err  = timeout && !s_data_valid;

                if (grant_q[1]) begin
                    m1_data_valid = done;
                    m1_rd_data    = done ? rsp_data : '0;
                end else begin
                    m0_data_valid = done;
                    m0_rd_data    = done ? rsp_data : '0;
                end

                if (done) begin
                    state_d = ST_IDLE;
                    grant_d = 2'b00;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                grant_d = 2'b00;
            end
        endcase
    end

    assign grant = grant_q;

endmodule

// File: tb/tb_soc_bus_arbiter.sv
// tb/tb_soc_bus_arbiter.sv - self-checking bench for soc_bus_arbiter
module tb_soc_bus_arbiter;

    localparam int TO = 256;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        programming = 1'b0;
    logic        m0_req_valid = 1'b0, m0_we = 1'b0;
    logic [31:0] m0_addr = '0, m0_wrt_data = '0;
    logic [31:0] m0_rd_data;
    logic        m0_data_valid;
    logic        m1_req_valid = 1'b0, m1_we = 1'b0;
    logic [31:0] m1_addr = '0, m1_wrt_data = '0;
    logic [31:0] m1_rd_data;
    logic        m1_data_valid;
    logic        s_req_valid, s_we;
    logic [31:0] s_addr, s_wrt_data;
    logic [31:0] s_rd_data = '0;
    logic        s_data_valid = 1'b0;
    logic [1:0]  grant;
    logic        bus_err;

    always #5 clk = ~clk;

    soc_bus_arbiter #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(TO), .ERR_DATA(32'hDEADBEEF)
    ) dut (
        .clk(clk), .reset(reset), .programming(programming),
        .m0_req_valid(m0_req_valid), .m0_addr(m0_addr), .m0_we(m0_we),
        .m0_wrt_data(m0_wrt_data), .m0_rd_data(m0_rd_data), .m0_data_valid(m0_data_valid),
        .m1_req_valid(m1_req_valid), .m1_addr(m1_addr), .m1_we(m1_we),
        .m1_wrt_data(m1_wrt_data), .m1_rd_data(m1_rd_data), .m1_data_valid(m1_data_valid),
        .s_req_valid(s_req_valid), .s_addr(s_addr), .s_we(s_we), .s_wrt_data(s_wrt_data),
        .s_rd_data(s_rd_data), .s_data_valid(s_data_valid),
        .grant(grant), .bus_err(bus_err)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          master;
        logic [31:0] data;
        logic        err;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        logic        m0_req;
        logic [31:0] m0_addr;
        logic        m0_we;
        logic [31:0] m0_wd;
        logic        m1_req;
        logic [31:0] m1_addr;
        logic        m1_we;
        logic [31:0] m1_wd;
        int          lat;
        logic [31:0] key;
        int          first;
    } vec_t;
    vec_t vecs[7];

    // completions seen by the monitor, per master
    int done0 = 0;
    int done1 = 0;

    // slave model: responds slv_lat cycles after the first BUSY cycle
    // (-1 = never) with s_addr ^ slv_key
    int          slv_lat = -1;
    logic [31:0] slv_key = '0;
    int          slv_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic push_exp(input int master, input logic [31:0] data, input logic err);
        exp_t e;
        e.master = master;
        e.data   = data;
        e.err    = err;
        exp_q.push_back(e);
    endtask

    always @(posedge clk) begin
        #1;
        if (reset) begin
            s_data_valid = 1'b0;
            slv_cnt      = 0;
        end else if (s_data_valid) begin
            s_data_valid = 1'b0;
            s_rd_data    = '0;
            slv_cnt      = 0;
        end else if (s_req_valid) begin
            if (slv_lat >= 0 && slv_cnt == slv_lat) begin
                s_data_valid = 1'b1;
                s_rd_data    = s_addr ^ slv_key;
            end
            slv_cnt++;
        end else begin
            slv_cnt = 0;
        end
    end

    // scoreboard monitor
    always @(negedge clk) begin
        exp_t        e;
        int          who;
        logic [31:0] got;
        if (m0_data_valid && m1_data_valid) begin
            checks++;
            errors++;
            $display("FAIL dv_both m0_dv=1 m1_dv=1 required one owner");
        end else if (m0_data_valid || m1_data_valid) begin
            who = m1_data_valid ? 1 : 0;
            got = m1_data_valid ? m1_rd_data : m0_rd_data;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_dv master=%0d rd_data=%h required no completion", who, got);
            end else begin
                e = exp_q.pop_front();
                if (e.master != who || e.data !== got || e.err !== bus_err) begin
                    errors++;
                    $display("FAIL scoreboard master=%0d rd_data=%h bus_err=%0b required master=%0d rd_data=%h bus_err=%0b",
                             who, got, bus_err, e.master, e.data, e.err);
                end
            end
            if (who == 1) done1++;
            else          done0++;
            if ((who == 1 && m0_rd_data != 0) || (who == 0 && m1_rd_data != 0)) begin
                errors++;
                $display("FAIL non_owner_rd_data m0=%h m1=%h required 0 on non-owner", m0_rd_data, m1_rd_data);
            end
        end else begin
            checks++;
            if (bus_err || m0_rd_data != 0 || m1_rd_data != 0) begin
                errors++;
                $display("FAIL quiet_outputs bus_err=%0b m0_rd=%h m1_rd=%h required 0", bus_err, m0_rd_data, m1_rd_data);
            end
        end
    end

    task automatic gap_check(input int who, input logic [31:0] addr);
        @(negedge clk);
        chk("idle_gap", {grant, s_req_valid}, 3'b000);
        @(negedge clk);
        chk("second_grant", {grant, s_req_valid}, {(who == 1) ? 2'b10 : 2'b01, 1'b1});
        chk("second_addr", s_addr, addr);
    endtask

    // called at posedge+1 with the arbiter idle; returns the same way
    task automatic run_row(input vec_t v);
        int   s0, s1, budget;
        bit   pend0, pend1;
        logic [31:0] fa, fwd, sa;
        logic        fwe;
        s0 = done0;
        s1 = done1;
        slv_lat = v.lat;
        slv_key = v.key;
        m0_addr = v.m0_addr; m0_we = v.m0_we; m0_wrt_data = v.m0_wd;
        m1_addr = v.m1_addr; m1_we = v.m1_we; m1_wrt_data = v.m1_wd;
        m0_req_valid = v.m0_req;
        m1_req_valid = v.m1_req;
        pend0 = v.m0_req;
        pend1 = v.m1_req;
        fa  = (v.first == 1) ? v.m1_addr : v.m0_addr;
        fwe = (v.first == 1) ? v.m1_we   : v.m0_we;
        fwd = (v.first == 1) ? v.m1_wd   : v.m0_wd;
        sa  = (v.first == 1) ? v.m0_addr : v.m1_addr;
        push_exp(v.first, fa ^ v.key, 1'b0);
        if (v.m0_req && v.m1_req) push_exp(1 - v.first, sa ^ v.key, 1'b0);

        @(posedge clk);
        @(negedge clk);
        chk("first_grant", {grant, s_req_valid, s_we}, {(v.first == 1) ? 2'b10 : 2'b01, 1'b1, fwe});
        chk("first_fields", {s_addr, s_wrt_data}, {fa, fwd});

        budget = 0;
        while ((pend0 || pend1) && budget < TO + 20) begin
            @(posedge clk);
            #1;
            budget++;
            if (pend0 && done0 != s0) begin
                m0_req_valid = 1'b0;
                pend0 = 0;
                if (pend1) gap_check(1, v.m1_addr);
            end else if (pend1 && done1 != s1) begin
                m1_req_valid = 1'b0;
                pend1 = 0;
                if (pend0) gap_check(0, v.m0_addr);
            end
        end
        chk("row_complete", {31'd0, pend0, pend1}, 64'd0);
        @(negedge clk);
        chk("row_end_idle", {grant, s_req_valid}, 3'b000);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int s0, s1, bad, budget;

        vecs[0] = '{1'b1, 32'h100, 1'b0, 32'h0,        1'b1, 32'h200, 1'b0, 32'h0, 2,      32'h11110000, 0};
        vecs[1] = '{1'b1, 32'h000, 1'b0, 32'h0,        1'b0, 32'h000, 1'b0, 32'h0, 3,      32'h00001234, 0};
        vecs[2] = '{1'b1, 32'h300, 1'b1, 32'hCAFE,     1'b1, 32'h400, 1'b0, 32'h0, 1,      32'h0F0F0000, 1};
        vecs[3] = '{1'b0, 32'h000, 1'b0, 32'h0,        1'b1, 32'h040, 1'b1, 32'hA5, 0,     32'h00FF0000, 1};
        vecs[4] = '{1'b1, 32'h080, 1'b1, 32'h5555AAAA, 1'b0, 32'h000, 1'b0, 32'h0, 5,      32'h77770000, 0};
        vecs[5] = '{1'b1, 32'h010, 1'b0, 32'h0,        1'b1, 32'h020, 1'b0, 32'h0, 0,      32'h22220000, 1};
        vecs[6] = '{1'b0, 32'h000, 1'b0, 32'h0,        1'b1, 32'h030, 1'b0, 32'h0, TO - 1, 32'h0BAD0000, 1};

        // reset holds everything at zero even with a request pending
        m0_req_valid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_ctrl", {grant, s_req_valid, s_we, m0_data_valid, m1_data_valid, bus_err}, 64'd0);
        chk("reset_bus", {s_addr, s_wrt_data}, 64'd0);
        @(posedge clk);
        #1;
        m0_req_valid = 1'b0;
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 7; i++) run_row(vecs[i]);

        // loader mode: m0 is held off until programming drops
        programming = 1'b1;
        slv_lat = 1;
        slv_key = 32'hAB000000;
        m0_addr = 32'h500; m0_we = 1'b0;
        m1_addr = 32'h600; m1_we = 1'b0;
        m0_req_valid = 1'b1;
        m1_req_valid = 1'b1;
        s0 = done0;
        s1 = done1;
        push_exp(1, 32'h600 ^ 32'hAB000000, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk("prog_grant_m1", grant, 2'b10);
        budget = 0;
        while (done1 == s1 && budget < 20) begin
            @(posedge clk);
            #1;
            budget++;
        end
        chk("prog_m1_done", done1 - s1, 1);
        m1_req_valid = 1'b0;
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (grant != 2'b00 || done0 != s0) bad++;
        end
        chk("prog_blocks_m0", bad, 0);
        @(posedge clk);
        #1;
        programming = 1'b0;
        push_exp(0, 32'h500 ^ 32'hAB000000, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk("m0_after_prog", grant, 2'b01);
        budget = 0;
        while (done0 == s0 && budget < 20) begin
            @(posedge clk);
            #1;
            budget++;
        end
        chk("m0_after_prog_done", done0 - s0, 1);
        m0_req_valid = 1'b0;
        @(posedge clk);
        #1;

        // slave never answers: abort on BUSY cycle TO
        slv_lat = -1;
        m0_addr = 32'h700;
        m0_we = 1'b0;
        m0_req_valid = 1'b1;
        push_exp(0, 32'hDEADBEEF, 1'b1);
        @(posedge clk);
        bad = 0;
        for (int i = 1; i <= TO; i++) begin
            @(negedge clk);
            if (i < TO && (m0_data_valid || bus_err || !s_req_valid)) bad++;
        end
        chk("no_early_abort", bad, 0);
        chk("timeout_cycle", {m0_data_valid, bus_err, m0_rd_data}, {1'b1, 1'b1, 32'hDEADBEEF});
        @(posedge clk);
        #1;
        m0_req_valid = 1'b0;
        @(negedge clk);
        chk("idle_after_timeout", {grant, s_req_valid, bus_err}, 4'b0000);
        @(posedge clk);
        #1;

        // m1 write, then reset pulsed mid-BUSY
        slv_lat = -1;
        m1_addr = 32'h40;
        m1_we = 1'b1;
        m1_wrt_data = 32'hA5;
        m1_req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("m1_write_ctrl", {grant, s_req_valid, s_we}, {2'b10, 1'b1, 1'b1});
        chk("m1_write_bus", {s_addr, s_wrt_data}, {32'h40, 32'hA5});
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_ctrl", {grant, s_req_valid, s_we}, 4'b0000);
        chk("async_reset_bus", {s_addr, s_wrt_data}, 64'd0);
        m1_req_valid = 1'b0;
        m1_we = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // arbiter recovers after the lost transaction
        run_row('{1'b1, 32'h900, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1, 32'h3C3C0000, 0});

        chk("scoreboard_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
